// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register, two-entry (main + skid) valid/ready
//            buffer with registered in_ready and wrong-path flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP_IR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc_plus_4,
    input  logic [DATA_W-1:0] in_ir,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc_plus_4,
    output logic [DATA_W-1:0] out_ir,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_ir;
    logic [DATA_W-1:0] r_main_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_ir;
    logic [DATA_W-1:0] r_skid_pc;
    logic              r_in_ready;
    logic [1:0]        r_occupancy;

    logic              w_accept;
    logic              w_issue;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_ir_nxt;
    logic [DATA_W-1:0] w_main_pc_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_ir_nxt;
    logic [DATA_W-1:0] w_skid_pc_nxt;

    assign w_accept = in_valid & r_in_ready;
    assign w_issue  = r_main_valid & out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_ir_nxt    = r_main_ir;
        w_main_pc_nxt    = r_main_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_ir_nxt    = r_skid_ir;
        w_skid_pc_nxt    = r_skid_pc;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_ir_nxt    = NOP_IR;
            w_main_pc_nxt    = '0;
            w_skid_valid_nxt = 1'b0;
            w_skid_ir_nxt    = NOP_IR;
            w_skid_pc_nxt    = '0;
        end else if (!r_main_valid || (w_issue && !r_skid_valid)) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_ir_nxt    = in_ir;
                w_main_pc_nxt    = in_pc_plus_4;
            end else begin
                w_main_valid_nxt = 1'b0;
                w_main_ir_nxt    = NOP_IR;
                w_main_pc_nxt    = '0;
            end
        end else if (w_issue) begin
            // Skid is full here, so in_ready is low and nothing is accepted.
            w_main_valid_nxt = 1'b1;
            w_main_ir_nxt    = r_skid_ir;
            w_main_pc_nxt    = r_skid_pc;
            w_skid_valid_nxt = 1'b0;
            w_skid_ir_nxt    = NOP_IR;
            w_skid_pc_nxt    = '0;
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_ir_nxt    = in_ir;
            w_skid_pc_nxt    = in_pc_plus_4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_main_ir    <= NOP_IR;
            r_main_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ir    <= NOP_IR;
            r_skid_pc    <= '0;
            r_in_ready   <= 1'b1;
            r_occupancy  <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_ir    <= w_main_ir_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_ir    <= w_skid_ir_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            // Registered copies track the next-state valids so they stay in step.
            r_in_ready   <= ~w_skid_valid_nxt;
            r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_main_valid;
    assign out_ir        = r_main_ir;
    assign out_pc_plus_4 = r_main_pc;
    assign occupancy     = r_occupancy;

endmodule
`default_nettype wire
